// File: rtl/sm4_rkey_scheduler.sv
// sm4_rkey_scheduler
// SM4 key-expansion engine. Accepts a 128-bit master key over a valid/ready
// handshake, expands the 32 round keys one per cycle into an internal store,
// and serves them to the round engine in forward (encrypt) or reverse
// (decrypt) order through a 1-cycle registered read port.
//
// Optional feature macro: SM4_RKEY_ZEROIZE_EN
//   When defined, adds input zeroize_i which clears the store and key window,
//   returns to IDLE and suppresses reads. It has priority over key accept and
//   read requests. When undefined, stored keys persist until overwritten or
//   reset.
//
// Ports
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   zeroize_i    (SM4_RKEY_ZEROIZE_EN only) wipe schedule, back to IDLE
//   key_v_i      master key valid
//   key_i        master key, MK0 = key_i[127:96] .. MK3 = key_i[31:0]
//   key_ready_o  scheduler can accept a master key (IDLE or READY)
//   keys_v_o     all round keys stored and readable
//   busy_o       expansion in progress
//   rkey_req_i   round-key read request
//   round_i      requested round number
//   decrypt_i    0: rk[round_i], 1: rk[rounds_p-1-round_i]
//   rkey_o       requested round key (registered)
//   rkey_v_o     rkey_o valid (registered)

module sm4_rkey_scheduler #(
   parameter int unsigned rounds_p    = 32,
   parameter int unsigned idx_width_p = $clog2(rounds_p)
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
`ifdef SM4_RKEY_ZEROIZE_EN
   input  logic                   zeroize_i,
`endif
   input  logic                   key_v_i,
   input  logic [127:0]           key_i,
   output logic                   key_ready_o,
   output logic                   keys_v_o,
   output logic                   busy_o,
   input  logic                   rkey_req_i,
   input  logic [idx_width_p-1:0] round_i,
   input  logic                   decrypt_i,
   output logic [31:0]            rkey_o,
   output logic                   rkey_v_o
);

   localparam int unsigned word_w_lp = 32;

   // System parameter FK, FK0 first
   localparam logic [0:3][word_w_lp-1:0] fk_tbl = {
      32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
   };

   // SM4 S-box, entry 0 first
   localparam logic [0:255][7:0] sbox_tbl = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   typedef enum logic [1:0] {
      st_idle   = 2'd0,
      st_expand = 2'd1,
      st_ready  = 2'd2
   } state_e;

   state_e                 state_q;
   logic [idx_width_p-1:0] cnt_q;
   logic [word_w_lp-1:0]   k_q     [4];
   logic [word_w_lp-1:0]   store_q [rounds_p];
   logic [word_w_lp-1:0]   rkey_q;
   logic                   rkey_v_q;
   logic                   key_ready_q;
   logic                   keys_v_q;
   logic                   busy_q;

   logic                   zero_c;
   logic                   accept_c;
   logic [word_w_lp-1:0]   ck_c;
   logic [word_w_lp-1:0]   b_c;
   logic [word_w_lp-1:0]   s_c;
   logic [word_w_lp-1:0]   rk_d;
   logic                   rd_ok_c;
   logic [idx_width_p-1:0] rd_idx_c;

`ifdef SM4_RKEY_ZEROIZE_EN
   assign zero_c = zeroize_i;
`else
   assign zero_c = 1'b0;
`endif

   // key_ready_q is only high in IDLE/READY, so it alone gates the accept
   assign accept_c = key_v_i & key_ready_q;

   // One expansion step: CK_i, nonlinear S layer, L' diffusion
   always_comb begin
      ck_c = '0;
      for (int j = 0; j < 4; j++) begin
         ck_c[31-8*j -: 8] = 8'((32'(cnt_q) * 32'd4 + 32'(j)) * 32'd7);
      end
      b_c  = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_c;
      s_c  = {sbox_tbl[b_c[31:24]], sbox_tbl[b_c[23:16]],
              sbox_tbl[b_c[15:8]],  sbox_tbl[b_c[7:0]]};
      rk_d = k_q[0] ^ s_c ^ {s_c[18:0], s_c[31:19]} ^ {s_c[8:0], s_c[31:9]};
   end

   // Read selection; out-of-range rounds are refused
   always_comb begin
      rd_ok_c  = (state_q == st_ready) && (32'(round_i) < rounds_p);
      rd_idx_c = round_i;
      if (decrypt_i) begin
         rd_idx_c = idx_width_p'(rounds_p - 32'd1 - 32'(round_i));
      end
   end

   // FSM, key window, round-key store and registered read port
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= st_idle;
         cnt_q       <= '0;
         rkey_q      <= '0;
         rkey_v_q    <= 1'b0;
         key_ready_q <= 1'b0;
         keys_v_q    <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            k_q[i] <= '0;
         end
         for (int i = 0; i < int'(rounds_p); i++) begin
            store_q[i] <= '0;
         end
      end else if (zero_c) begin
         state_q     <= st_idle;
         cnt_q       <= '0;
         rkey_q      <= '0;
         rkey_v_q    <= 1'b0;
         key_ready_q <= 1'b1;
         keys_v_q    <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            k_q[i] <= '0;
         end
         for (int i = 0; i < int'(rounds_p); i++) begin
            store_q[i] <= '0;
         end
      end else begin
         // Read port sees the store as it is before this edge's write,
         // so a read issued together with an accept still gets old keys.
         if (rkey_req_i) begin
            if (rd_ok_c) begin
               rkey_q   <= store_q[rd_idx_c];
               rkey_v_q <= 1'b1;
            end else begin
               rkey_q   <= '0;
               rkey_v_q <= 1'b0;
            end
         end else begin
            rkey_v_q <= 1'b0;
         end

         case (state_q)
            st_idle, st_ready: begin
               if (accept_c) begin
                  for (int i = 0; i < 4; i++) begin
                     k_q[i] <= key_i[127-32*i -: 32] ^ fk_tbl[i];
                  end
                  cnt_q       <= '0;
                  state_q     <= st_expand;
                  key_ready_q <= 1'b0;
                  keys_v_q    <= 1'b0;
                  busy_q      <= 1'b1;
               end else begin
                  key_ready_q <= 1'b1;
               end
            end
            st_expand: begin
               store_q[cnt_q] <= rk_d;
               k_q[0]         <= k_q[1];
               k_q[1]         <= k_q[2];
               k_q[2]         <= k_q[3];
               k_q[3]         <= rk_d;
               cnt_q          <= cnt_q + idx_width_p'(1);
               if (32'(cnt_q) == rounds_p - 32'd1) begin
                  state_q     <= st_ready;
                  busy_q      <= 1'b0;
                  keys_v_q    <= 1'b1;
                  key_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= st_idle;
               key_ready_q <= 1'b0;
               keys_v_q    <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign key_ready_o = key_ready_q;
   assign keys_v_o    = keys_v_q;
   assign busy_o      = busy_q;
   assign rkey_o      = rkey_q;
   assign rkey_v_o    = rkey_v_q;

endmodule

// File: doc/sm4_rkey_scheduler.md
Name: sm4_rkey_scheduler

Overview:
- SM4 key-expansion engine; the producer of the `rkey_i` words that the round-function datapath consumes.
- Accepts a 128-bit master key over a valid/ready handshake. Generates the 32 round keys iteratively, one per cycle, into an internal 32x32 store.
- Serves them to the encrypt/decrypt round engine: forward order for encryption, reverse order for decryption.

Parameters:
- `rounds_p`, 32, number of round keys generated and stored; the full SM4 key schedule is 32.
- `idx_width_p`, `$clog2(rounds_p)`, width of the round index port.

Ports:
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  asynchronous active-low reset
- `key_v_i`  in  1  master key valid
- `key_i`  in  128  master key MK; MK0 = `key_i[127:96]`, MK3 = `key_i[31:0]`
- `key_ready_o`  out  1  scheduler can accept a master key
- `keys_v_o`  out  1  all `rounds_p` round keys stored and readable
- `busy_o`  out  1  expansion in progress
- `rkey_req_i`  in  1  round-key read request
- `round_i`  in  `idx_width_p`  round number requested by the round engine
- `decrypt_i`  in  1  0: return `rk[round_i]`; 1: return `rk[rounds_p-1-round_i]`
- `rkey_o`  out  32  requested round key
- `rkey_v_o`  out  1  `rkey_o` valid

Behaviour:
- Reset (asynchronous, `reset_n_i`=0) puts all outputs at 0, state at IDLE, the store at 0 and the round counter at 0.
- States:
  - IDLE: `key_ready_o`=1, `keys_v_o`=0.
  - EXPAND: `busy_o`=1, `key_ready_o`=0.
  - READY: `key_ready_o`=1, `keys_v_o`=1.
- Accept happens on `key_v_i` & `key_ready_o` at edge T, in IDLE or READY.
  - Load K0..K3 = MK0..MK3 XOR FK, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Clear the counter and enter EXPAND.
  - Drop `keys_v_o` in the cycle after T.
- EXPAND step i (0..`rounds_p`-1), one per cycle at edges T+1..T+`rounds_p`:
  - B = K(i+1) ^ K(i+2) ^ K(i+3) ^ CK_i.
  - rk_i = K_i ^ L'(S(B)), with L'(x) = x ^ (x<<<13) ^ (x<<<23) and S the byte-wise SM4 S-box.
  - Write rk_i to `store[i]`, then shift the window to K(i+1..i+4).
  - CK_i byte j (MSB first, j=0..3) = ((4i+j)*7) mod 256.
- After edge T+`rounds_p` writes rk31, go to READY. `keys_v_o`=1 from the cycle after T+`rounds_p` (33 cycles after accept).
- Read path (1-cycle registered):
  - `rkey_req_i` at edge N gives `rkey_o`/`rkey_v_o` at N+1.
  - A request in READY sets `rkey_v_o`=1 and returns the selected entry.
  - A request in IDLE or EXPAND sets `rkey_v_o`=0 and `rkey_o`=0.
  - No request sets `rkey_v_o`=0 and holds `rkey_o`.
- `round_i` >= `rounds_p` returns `rkey_o`=0 with `rkey_v_o`=0.
- A new key accepted in READY replaces the schedule:
  - a read request in the same cycle as the accept is still served from the old store;
  - from the next cycle reads are refused until the new schedule completes.
- `key_v_i` during EXPAND is ignored (`key_ready_o`=0); `key_i` is sampled only on accept.
- Reset asserted mid-EXPAND aborts immediately. The store is cleared and no partial keys are ever reported valid.

Optional Feature:
- `SM4_RKEY_ZEROIZE_EN`, with macro defined:
  - Adds input `zeroize_i` (1 bit).
  - When high at an edge: the store and K window clear to 0 at that edge, the state goes to IDLE, and `rkey_v_o` is 0 in the next cycle.
  - Zeroize has priority over a simultaneous key accept and over read requests.
- Without the macro:
  - The port is absent.
  - Stored keys persist until overwritten or reset.

Test Plan:
- Reset, then MK=0123456789ABCDEFFEDCBA9876543210 accepted at T:
  - `busy_o` is 1 for 32 cycles and `keys_v_o`=1 at T+33;
  - read round 0 encrypt gives F12186F9;
  - round 1 gives 41662B61;
  - round 31 gives 9124A012.
- Same key, read with `decrypt_i`=1: round 0 gives 9124A012 and round 31 gives F12186F9, each with `rkey_v_o`=1 exactly one cycle after the request.
- Read requests during EXPAND and before any key: `rkey_v_o`=0, `rkey_o`=0. `key_v_i` held high during EXPAND: `key_ready_o`=0, no re-accept.
- From READY, accept MK=0 while reading round 5 in the same cycle:
  - that read returns the old rk5 with `rkey_v_o`=1;
  - the next read returns `rkey_v_o`=0;
  - after 33 cycles the new schedule is readable.
- Deassert `reset_n_i` at cycle T+10 of an expansion: outputs go to 0 asynchronously, the state is IDLE, and a subsequent read gives `rkey_v_o`=0.
- With `SM4_RKEY_ZEROIZE_EN`, pulse `zeroize_i` in READY:
  - `keys_v_o`=0 the next cycle;
  - reads are refused;
  - re-keying with the first MK regenerates F12186F9 at round 0.
